// File: rtl/threshold_config_multi_pkg.sv
// Shared types for the multi-channel threshold editor.
package threshold_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} step_state_t;

  typedef enum logic {BOUND_LOW, BOUND_HIGH} bound_sel_t;

  // Channel index width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/threshold_config_multi_if.sv
// Button / config / bound bus between the board front-end and the editor.
interface threshold_config_multi_if #(
  parameter int WIDTH  = 12,
  parameter int NUM_CH = 4
);
  import threshold_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic                      btnu;
  logic                      btnd;
  logic                      btnl;
  logic                      btnr;
  logic                      threshold_on;
  logic                      threshold_lowhi;
  logic                      step_coarse;
  logic [NUM_CH*WIDTH-1:0]   lower_bound_out;
  logic [NUM_CH*WIDTH-1:0]   upper_bound_out;
  logic [CH_W-1:0]           sel_ch_out;
  logic                      update_out;

  modport master (
    output btnu, btnd, btnl, btnr, threshold_on, threshold_lowhi, step_coarse,
    input  lower_bound_out, upper_bound_out, sel_ch_out, update_out
  );

  modport slave (
    input  btnu, btnd, btnl, btnr, threshold_on, threshold_lowhi, step_coarse,
    output lower_bound_out, upper_bound_out, sel_ch_out, update_out
  );

endinterface

// File: rtl/threshold_config_multi_button_debounce.sv
// One board button: 2-flop synchroniser, stable-sample debouncer, press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_raw,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [1:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          armed_q, armed_d;

  // Count consecutive synchronised samples that disagree with the accepted
  // level; flip once DEBOUNCE_CYCLES of them arrive in a row. A button that is
  // already held when reset releases is not reported as a press: presses are
  // only armed after a genuine released sample has passed the synchroniser.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    fill_d  = {fill_q[0], 1'b1};
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    armed_d = armed_q | (fill_q[1] & ~sync_q[1] & ~level_q);
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      press_d = sync_q[1] & armed_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset means "released, not yet armed".
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      armed_q <= armed_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/threshold_config_multi.sv
// Per-channel lower/upper bound editor driven by four debounced buttons,
// with hold-to-repeat stepping and lower <= upper kept at all times.
module threshold_config_multi
  import threshold_pkg::*;
#(
  parameter int WIDTH           = 12,
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int STEP_FINE       = 1,
  parameter int STEP_COARSE     = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  threshold_config_multi_if.slave  bus
);

  localparam int CH_W    = ch_width(NUM_CH);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W    = $clog2(RPT_MAX + 1);
  localparam logic [WIDTH-1:0] MAXV     = '1;
  localparam logic [WIDTH:0]   S_FINE   = (WIDTH+1)'(STEP_FINE);
  localparam logic [WIDTH:0]   S_COARSE = (WIDTH+1)'(STEP_COARSE);

  // Button order: 0 = up, 1 = down, 2 = left, 3 = right.
  logic [3:0] raw, lvl, prs;
  logic       unused_lr_lvl;

  assign raw = {bus.btnr, bus.btnl, bus.btnd, bus.btnu};
  assign unused_lr_lvl = ^lvl[3:2];

  for (genvar b = 0; b < 4; b++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .btn_raw (raw[b]),
      .level_o (lvl[b]),
      .press_o (prs[b])
    );
  end

  step_state_t       state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              up_q, up_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic              step_fire, step_up;

  logic [WIDTH-1:0]  lo_q [NUM_CH];
  logic [WIDTH-1:0]  lo_d [NUM_CH];
  logic [WIDTH-1:0]  hi_q [NUM_CH];
  logic [WIDTH-1:0]  hi_d [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] lo_out_q, lo_out_d, hi_out_q, hi_out_d;
  logic              upd_q, upd_d;

  // Step FSM: first step on the press, then one after REPEAT_DELAY, then one
  // every REPEAT_RATE. Releasing, pressing the opposite button, or disabling
  // edits drops back to IDLE without a step.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    up_d      = up_q;
    step_fire = 1'b0;
    step_up   = up_q;
    case (state_q)
      IDLE: begin
        if (bus.threshold_on && (prs[0] || prs[1]) && (lvl[0] ^ lvl[1])) begin
          step_fire = 1'b1;
          step_up   = lvl[0];
          up_d      = lvl[0];
          state_d   = HOLD;
          rcnt_d    = '0;
        end
      end
      default: begin
        if (!bus.threshold_on || !(up_q ? lvl[0] : lvl[1]) || (up_q ? lvl[1] : lvl[0])) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (state_q == HOLD) begin
          if (rcnt_q == RC_W'(REPEAT_DELAY - 1)) begin
            step_fire = 1'b1;
            state_d   = REPEAT;
            rcnt_d    = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end else begin
          if (rcnt_q == RC_W'(REPEAT_RATE - 1)) begin
            step_fire = 1'b1;
            rcnt_d    = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Channel select: left/right step with wrap; simultaneous presses cancel.
  always_comb begin
    sel_d = sel_q;
    if (prs[2] && !prs[3]) begin
      sel_d = (sel_q == '0) ? CH_W'(NUM_CH - 1) : sel_q - 1'b1;
    end else if (prs[3] && !prs[2]) begin
      sel_d = (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  // Bound update: one extra bit catches overflow/borrow, then each bound is
  // clamped against MAX/0 and against its partner so lower <= upper holds.
  logic [WIDTH-1:0] cur_l, cur_u, cur_v, nv;
  logic [WIDTH:0]   ext, stp;
  bound_sel_t       bsel;

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    upd_d = 1'b0;
    cur_l = lo_q[sel_q];
    cur_u = hi_q[sel_q];
    stp   = bus.step_coarse ? S_COARSE : S_FINE;
    bsel  = bus.threshold_lowhi ? BOUND_HIGH : BOUND_LOW;
    cur_v = (bsel == BOUND_LOW) ? cur_l : cur_u;
    ext   = '0;
    nv    = cur_v;
    if (bsel == BOUND_LOW) begin
      if (step_up) begin
        ext = {1'b0, cur_l} + stp;
        nv  = (ext > {1'b0, cur_u}) ? cur_u : ext[WIDTH-1:0];
      end else begin
        ext = {1'b0, cur_l} - stp;
        nv  = ext[WIDTH] ? '0 : ext[WIDTH-1:0];
      end
    end else begin
      if (step_up) begin
        ext = {1'b0, cur_u} + stp;
        nv  = ext[WIDTH] ? MAXV : ext[WIDTH-1:0];
      end else begin
        ext = {1'b0, cur_u} - stp;
        nv  = (ext[WIDTH] || (ext[WIDTH-1:0] < cur_l)) ? cur_l : ext[WIDTH-1:0];
      end
    end
    if (step_fire && (nv != cur_v)) begin
      upd_d = 1'b1;
      if (bsel == BOUND_LOW) lo_d[sel_q] = nv;
      else                   hi_d[sel_q] = nv;
    end
  end

  // Presented bounds: stored values when enabled, full range when bypassed.
  always_comb begin
    lo_out_d = '0;
    hi_out_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lo_out_d[k*WIDTH +: WIDTH] = bus.threshold_on ? lo_d[k] : '0;
      hi_out_d[k*WIDTH +: WIDTH] = bus.threshold_on ? hi_d[k] : MAXV;
    end
  end

  // Control registers: FSM, repeat counter, direction, selected channel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      up_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      up_q    <= up_d;
      sel_q   <= sel_d;
    end
  end

  // Stored bounds and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_CH; k++) begin
        lo_q[k] <= '0;
        hi_q[k] <= MAXV;
      end
      lo_out_q <= '0;
      hi_out_q <= '1;
      upd_q    <= 1'b0;
    end else begin
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      lo_out_q <= lo_out_d;
      hi_out_q <= hi_out_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.lower_bound_out = lo_out_q;
  assign bus.upper_bound_out = hi_out_q;
  assign bus.sel_ch_out      = sel_q;
  assign bus.update_out      = upd_q;

endmodule

// File: tb/tb_threshold_config_multi.sv
// Directed bench: expected bound vectors queued per step, checked on each
// update pulse; direct checks for select, clamping, bypass and reset.
module tb_threshold_config_multi;

  localparam int W = 12;
  localparam int N = 4;
  localparam logic [N*W-1:0] ALL_MAX = {N{12'hFFF}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  threshold_config_multi_if #(.WIDTH(W), .NUM_CH(N)) bus ();

  threshold_config_multi #(
    .WIDTH(W), .NUM_CH(N), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16),
    .REPEAT_RATE(4), .STEP_FINE(1), .STEP_COARSE(64)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct { logic [N*W-1:0] lo; logic [N*W-1:0] hi; } sb_t;
  sb_t sbq [$];

  int errors = 0;
  int checks = 0;
  int exp_lo [N];
  int exp_hi [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_lo();
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = W'(exp_lo[k]);
    return p;
  endfunction

  function automatic logic [N*W-1:0] pack_hi();
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = W'(exp_hi[k]);
    return p;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < N; k++) begin
      exp_lo[k] = 0;
      exp_hi[k] = 4095;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue n successive steps of dlt on one bound.
  task automatic expect_steps(input int ch, input bit hi, input int n, input int dlt);
    for (int k = 0; k < n; k++) begin
      if (hi) exp_hi[ch] += dlt;
      else    exp_lo[ch] += dlt;
      sbq.push_back('{pack_lo(), pack_hi()});
    end
  endtask

  task automatic expect_set(input int ch, input bit hi, input int v);
    if (hi) exp_hi[ch] = v;
    else    exp_lo[ch] = v;
    sbq.push_back('{pack_lo(), pack_hi()});
  endtask

  // Hold u/d long enough for exactly n steps (press step, +16, then every 4),
  // releasing so the debounced release lands between step n and step n+1.
  task automatic hold_btn(input bit up, input int n);
    int r;
    r = (n == 1) ? 10 : 18 + 4 * (n - 2);
    if (up) bus.btnu = 1'b1;
    else    bus.btnd = 1'b1;
    repeat (r) cyc();
    bus.btnu = 1'b0;
    bus.btnd = 1'b0;
    repeat (14) cyc();
  endtask

  task automatic sel_press(input bit right, input int exp_sel, input string tag);
    if (right) bus.btnr = 1'b1;
    else       bus.btnl = 1'b1;
    repeat (10) cyc();
    chk(tag, 64'(bus.sel_ch_out), 64'(exp_sel));
    bus.btnr = 1'b0;
    bus.btnl = 1'b0;
    repeat (14) cyc();
  endtask

  // Scoreboard consumer: every update pulse must match the next queued entry.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.update_out === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("spurious_update", 64'(bus.update_out), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("sb_lower", 64'(bus.lower_bound_out), 64'(e.lo));
          chk("sb_upper", 64'(bus.upper_bound_out), 64'(e.hi));
        end
      end
    end
  end

  initial begin
    reset_model();
    bus.btnu = 1'b0; bus.btnd = 1'b0; bus.btnl = 1'b0; bus.btnr = 1'b0;
    bus.threshold_on = 1'b1; bus.threshold_lowhi = 1'b0; bus.step_coarse = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("rst_lower", 64'(bus.lower_bound_out), 64'(0));
    chk("rst_upper", 64'(bus.upper_bound_out), 64'(ALL_MAX));
    chk("rst_sel",   64'(bus.sel_ch_out), 64'(0));
    chk("rst_upd",   64'(bus.update_out), 64'(0));
    repeat (4) cyc();

    // Single fine increment of ch0 lower.
    expect_steps(0, 0, 1, 1);
    hold_btn(1'b1, 1);

    // Bouncy right press counts once, then walk and wrap the select.
    bus.btnr = 1'b1; repeat (2) cyc();
    bus.btnr = 1'b0; repeat (2) cyc();
    bus.btnr = 1'b1; repeat (12) cyc();
    chk("sel_bounce", 64'(bus.sel_ch_out), 64'(1));
    bus.btnr = 1'b0; repeat (14) cyc();
    sel_press(1'b1, 2, "sel_r2");
    sel_press(1'b1, 3, "sel_r3");
    sel_press(1'b1, 0, "sel_wrap0");
    sel_press(1'b0, 3, "sel_l_wrap3");
    sel_press(1'b0, 2, "sel_l2");

    // Held coarse decrement of ch2 upper with auto-repeat.
    bus.threshold_lowhi = 1'b1; bus.step_coarse = 1'b1;
    expect_steps(2, 1, 4, -64);
    hold_btn(1'b0, 4);
    sel_press(1'b0, 1, "sel_l1");

    // Bring ch1 to lower=100, upper=120.
    expect_steps(1, 1, 62, -64);  hold_btn(1'b0, 62);
    bus.step_coarse = 1'b0;
    expect_steps(1, 1, 7, -1);    hold_btn(1'b0, 7);
    bus.threshold_lowhi = 1'b0; bus.step_coarse = 1'b1;
    expect_steps(1, 0, 1, 64);    hold_btn(1'b1, 1);
    bus.step_coarse = 1'b0;
    expect_steps(1, 0, 36, 1);    hold_btn(1'b1, 36);

    // Clamps: lower inc stops at upper; upper dec at lower is a silent no-op.
    bus.step_coarse = 1'b1;
    expect_set(1, 0, 120);        hold_btn(1'b1, 1);
    bus.threshold_lowhi = 1'b1; bus.step_coarse = 1'b0;
    hold_btn(1'b0, 1);
    chk("clamp_hi_noop", 64'(bus.upper_bound_out[1*W +: W]), 64'(120));
    bus.threshold_lowhi = 1'b0; bus.step_coarse = 1'b1;
    expect_steps(1, 0, 1, -64);   hold_btn(1'b0, 1);
    bus.step_coarse = 1'b0;
    expect_steps(1, 0, 26, -1);   hold_btn(1'b0, 26);
    bus.step_coarse = 1'b1;
    expect_set(1, 0, 0);          hold_btn(1'b0, 1);

    // Bypass: full-range outputs, buttons ignored, stored values come back.
    bus.threshold_on = 1'b0;
    repeat (2) cyc();
    chk("byp_lower", 64'(bus.lower_bound_out), 64'(0));
    chk("byp_upper", 64'(bus.upper_bound_out), 64'(ALL_MAX));
    hold_btn(1'b1, 1);
    chk("byp_lower_after_btn", 64'(bus.lower_bound_out), 64'(0));
    bus.threshold_on = 1'b1;
    repeat (2) cyc();
    chk("restore_lower", 64'(bus.lower_bound_out), 64'(pack_lo()));
    chk("restore_upper", 64'(bus.upper_bound_out), 64'(pack_hi()));

    // Async reset in the middle of auto-repeat on ch1 lower (fine, up).
    bus.step_coarse = 1'b0;
    expect_steps(1, 0, 3, 1);
    bus.btnu = 1'b1;
    repeat (29) cyc();
    #3 rst = 1'b1;
    #1;
    chk("arst_lower", 64'(bus.lower_bound_out), 64'(0));
    chk("arst_upper", 64'(bus.upper_bound_out), 64'(ALL_MAX));
    chk("arst_sel",   64'(bus.sel_ch_out), 64'(0));
    chk("arst_upd",   64'(bus.update_out), 64'(0));
    reset_model();
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    repeat (40) cyc();
    chk("held_after_rst_lower", 64'(bus.lower_bound_out), 64'(0));
    chk("held_after_rst_upper", 64'(bus.upper_bound_out), 64'(ALL_MAX));
    bus.btnu = 1'b0;
    repeat (14) cyc();
    expect_steps(0, 0, 1, 1);
    hold_btn(1'b1, 1);
    chk("repress_lower", 64'(bus.lower_bound_out), 64'(pack_lo()));

    repeat (5) cyc();
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
